// File: rtl/sm_run_ctrl.sv
// sm_run_ctrl: run / halt / single-step controller for the schoolMIPS core.
// Gates the core's clock enable so a debug host can halt the core, let it run
// free, step it a given number of instructions, or stop it on a word-PC
// breakpoint. The core is single-cycle, so one enabled clock retires exactly
// one instruction, and the retired counter simply counts enabled cycles.
module sm_run_ctrl #(
    parameter int PC_W   = 32,
    parameter int STEP_W = 16,
    parameter int PERF_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [STEP_W-1:0] cmd_count,
    input  logic              bp_en,
    input  logic [PC_W-1:0]   bp_pc,
    input  logic [PC_W-1:0]   cpu_pc,
    output logic              cpu_clk_en,
    output logic [1:0]        state,
    output logic [1:0]        halt_cause,
    output logic [STEP_W-1:0] step_left,
    output logic [PERF_W-1:0] retired
);

    typedef enum logic [1:0] {
        ST_HALTED   = 2'd0,
        ST_RUNNING  = 2'd1,
        ST_STEPPING = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        CAUSE_RESET    = 2'd0,
        CAUSE_HOST     = 2'd1,
        CAUSE_BREAK    = 2'd2,
        CAUSE_STEPDONE = 2'd3
    } cause_t;

    localparam logic [1:0] OP_HALT   = 2'd0;
    localparam logic [1:0] OP_RUN    = 2'd1;
    localparam logic [1:0] OP_STEP   = 2'd2;
    localparam logic [1:0] OP_CLRCNT = 2'd3;

    // Registered state
    state_t              r_state;
    cause_t              r_cause;
    logic [STEP_W-1:0]   r_step_left;
    logic [PERF_W-1:0]   r_retired;
    logic                r_bp_skip;

    // Next-state values
    state_t              w_state_next;
    cause_t              w_cause_next;
    logic [STEP_W-1:0]   w_step_left_next;
    logic [PERF_W-1:0]   w_retired_next;
    logic                w_bp_skip_next;

    // Combinational helpers
    logic                w_cmd_acc;
    logic                w_bp_hit;
    logic                w_clk_en;
    logic                w_internal;
    logic [STEP_W-1:0]   w_step_load;

    // Command handshake, breakpoint match and core clock enable
    always_comb begin
        w_cmd_acc   = cmd_valid & ~rst;
        // bp_skip lets the instruction sitting on the breakpoint execute once
        // after the host resumes from a break halt.
        w_bp_hit    = bp_en & (cpu_pc == bp_pc) & ~r_bp_skip;
        // Steps deliberately ignore the breakpoint.
        w_clk_en    = ~rst & (((r_state == ST_RUNNING) & ~w_bp_hit) |
                              (r_state == ST_STEPPING));
        // A step count of zero still executes one instruction.
        w_step_load = (cmd_count == '0) ? STEP_W'(1) : cmd_count;
        // CLRCNT only touches the counter, so internal events still proceed
        // when it is the accepted command; any other command overrides them.
        w_internal  = ~w_cmd_acc | (cmd_op == OP_CLRCNT);
    end

    // Next-state logic: host commands first, then breakpoint / step events
    always_comb begin
        w_state_next     = r_state;
        w_cause_next     = r_cause;
        w_step_left_next = r_step_left;
        // bp_skip is one-shot: it dies on the first enabled cycle.
        w_bp_skip_next   = w_clk_en ? 1'b0 : r_bp_skip;

        if (w_internal) begin
            case (r_state)
                ST_RUNNING: begin
                    if (w_bp_hit) begin
                        w_state_next = ST_HALTED;
                        w_cause_next = CAUSE_BREAK;
                    end
                end
                ST_STEPPING: begin
                    if (r_step_left <= STEP_W'(1)) begin
                        w_state_next     = ST_HALTED;
                        w_cause_next     = CAUSE_STEPDONE;
                        w_step_left_next = '0;
                    end else begin
                        w_step_left_next = r_step_left - STEP_W'(1);
                    end
                end
                default: ;
            endcase
        end

        if (w_cmd_acc) begin
            case (cmd_op)
                OP_HALT: begin
                    w_state_next     = ST_HALTED;
                    w_cause_next     = CAUSE_HOST;
                    w_step_left_next = '0;
                    w_bp_skip_next   = 1'b0;
                end
                OP_RUN: begin
                    if (r_state != ST_RUNNING) begin
                        w_state_next     = ST_RUNNING;
                        w_step_left_next = '0;
                        if ((r_state == ST_HALTED) && (r_cause == CAUSE_BREAK)) begin
                            w_bp_skip_next = 1'b1;
                        end
                    end
                end
                OP_STEP: begin
                    w_state_next     = ST_STEPPING;
                    w_step_left_next = w_step_load;
                    w_bp_skip_next   = 1'b0;
                end
                default: ;
            endcase
        end
    end

    // Retired-instruction counter: CLRCNT wins over the same-cycle increment
    always_comb begin
        w_retired_next = r_retired;
        if (w_cmd_acc && (cmd_op == OP_CLRCNT)) begin
            w_retired_next = '0;
        end else if (w_clk_en) begin
            w_retired_next = r_retired + PERF_W'(1);
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_HALTED;
            r_cause     <= CAUSE_RESET;
            r_step_left <= '0;
            r_retired   <= '0;
            r_bp_skip   <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_cause     <= w_cause_next;
            r_step_left <= w_step_left_next;
            r_retired   <= w_retired_next;
            r_bp_skip   <= w_bp_skip_next;
        end
    end

    // Output mapping
    always_comb begin
        cmd_ready  = ~rst;
        cpu_clk_en = w_clk_en;
        state      = r_state;
        halt_cause = r_cause;
        step_left  = r_step_left;
        retired    = r_retired;
    end

endmodule
